// File: rtl/traffic_pkg.sv
// Shared types, default durations and helpers for the countdown display.
package traffic_pkg;

  typedef enum logic [2:0] {
    NONE    = 3'd0,
    RED     = 3'd1,
    YEL     = 3'd2,
    GRN     = 3'd3,
    INVALID = 3'd4
  } phase_t;

  localparam int unsigned DEF_RED_TIME   = 30;
  localparam int unsigned DEF_YEL_TIME   = 5;
  localparam int unsigned DEF_GRN_TIME   = 60;
  localparam int unsigned DEF_FLASH_TIME = 10;
  localparam int unsigned MAX_TIME       = 99;

  // One-hot lamp pattern to phase; anything else is INVALID.
  function automatic phase_t decode_phase(input logic r, input logic y, input logic g);
    case ({r, y, g})
      3'b100:  return RED;
      3'b010:  return YEL;
      3'b001:  return GRN;
      default: return INVALID;
    endcase
  endfunction

  // Binary 0..99 to two packed BCD digits {tens, ones}.
  function automatic logic [7:0] to_bcd(input int unsigned v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Two-digit BCD down counter with synchronous load; saturates at 00.
module bcd_down_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       zero
);

  logic [3:0] next_tens;
  logic [3:0] next_ones;

  // Next count: load wins, otherwise borrow-aware decrement unless already 00.
  always_comb begin
    next_tens = tens;
    next_ones = ones;
    if (load) begin
      next_tens = load_val[7:4];
      next_ones = load_val[3:0];
    end else if (dec && !zero) begin
      if (ones == 4'd0) begin
        next_ones = 4'd9;
        next_tens = tens - 4'd1;
      end else begin
        next_ones = ones - 4'd1;
      end
    end
  end

  // Count register; zero flag tracks the registered value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tens <= 4'd0;
      ones <= 4'd0;
      zero <= 1'b1;
    end else begin
      tens <= next_tens;
      ones <= next_ones;
      zero <= (next_tens == 4'd0) && (next_ones == 4'd0);
    end
  end

endmodule

// File: rtl/traffic_countdown.sv
// Phase tracker, countdown display and pedestrian lamps driven from the
// traffic controller's red/yellow/green outputs.
module traffic_countdown
  import traffic_pkg::*;
#(
  parameter int unsigned RED_TIME   = DEF_RED_TIME,
  parameter int unsigned YEL_TIME   = DEF_YEL_TIME,
  parameter int unsigned GRN_TIME   = DEF_GRN_TIME,
  parameter int unsigned FLASH_TIME = DEF_FLASH_TIME
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       red,
  input  logic       yellow,
  input  logic       green,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       walk,
  output logic       ped_flash,
  output logic       dont_walk,
  output logic       phase_err,
  output logic       seq_err
);

  // Elaboration-time range checks on the timing parameters.
  if (RED_TIME < 1 || RED_TIME > MAX_TIME) begin : g_bad_red
    $fatal(1, "RED_TIME out of range 1..99");
  end
  if (YEL_TIME < 1 || YEL_TIME > MAX_TIME) begin : g_bad_yel
    $fatal(1, "YEL_TIME out of range 1..99");
  end
  if (GRN_TIME < 1 || GRN_TIME > MAX_TIME) begin : g_bad_grn
    $fatal(1, "GRN_TIME out of range 1..99");
  end
  if (FLASH_TIME > RED_TIME) begin : g_bad_flash
    $fatal(1, "FLASH_TIME exceeds RED_TIME");
  end

  localparam logic [6:0] RED_B   = 7'(RED_TIME);
  localparam logic [6:0] YEL_B   = 7'(YEL_TIME);
  localparam logic [6:0] GRN_B   = 7'(GRN_TIME);
  localparam logic [6:0] FLASH_B = 7'(FLASH_TIME);

  phase_t     cur_phase;
  phase_t     prev_phase;
  phase_t     last_colour;
  phase_t     next_prev;
  phase_t     next_last;

  logic       cnt_load;
  logic       cnt_dec;
  logic [7:0] cnt_load_val;
  logic       cnt_zero;
  logic [6:0] dur_bin;
  logic [6:0] cnt_bin;
  logic [6:0] next_bin;
  logic       is_change;
  logic       viol;
  logic       next_walk;
  logic       next_flash;

  assign cur_phase = decode_phase(red, yellow, green);

  // Phase history register; last_colour starts at GRN so a first RED is legal.
  always_ff @(posedge clk) begin
    if (!reset) begin
      prev_phase  <= NONE;
      last_colour <= GRN;
    end else begin
      prev_phase  <= next_prev;
      last_colour <= next_last;
    end
  end

  // Next phase history: remember every sample, and the last red/green seen.
  always_comb begin
    next_prev = cur_phase;
    next_last = last_colour;
    if (cur_phase == RED || cur_phase == GRN) begin
      next_last = cur_phase;
    end
  end

  // Counter control, sequence legality and next pedestrian lamp state.
  always_comb begin
    is_change = (cur_phase != prev_phase) && (cur_phase != INVALID);
    cnt_load  = is_change || (cur_phase == INVALID);
    cnt_dec   = !cnt_load;

    case (cur_phase)
      RED:     dur_bin = RED_B;
      YEL:     dur_bin = YEL_B;
      GRN:     dur_bin = GRN_B;
      default: dur_bin = 7'd0;
    endcase
    cnt_load_val = to_bcd(int'(dur_bin));

    viol = 1'b0;
    if (is_change) begin
      case (prev_phase)
        RED:     viol = (cur_phase == GRN);
        GRN:     viol = (cur_phase == RED);
        YEL:     viol = (cur_phase == last_colour);
        default: viol = 1'b0;
      endcase
    end

    cnt_bin = 7'(tens) * 7'd10 + 7'(ones);
    if (cnt_load) begin
      next_bin = dur_bin;
    end else if (cnt_zero) begin
      next_bin = 7'd0;
    end else begin
      next_bin = cnt_bin - 7'd1;
    end

    next_walk  = (cur_phase == RED) && (next_bin > FLASH_B);
    next_flash = (cur_phase == RED) && (next_bin != 7'd0) && (next_bin <= FLASH_B);
  end

  // Registered status and pedestrian outputs, aligned with the display.
  always_ff @(posedge clk) begin
    if (!reset) begin
      walk      <= 1'b0;
      ped_flash <= 1'b0;
      dont_walk <= 1'b1;
      phase_err <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      walk      <= next_walk;
      ped_flash <= next_flash;
      dont_walk <= !(next_walk || next_flash);
      phase_err <= (cur_phase == INVALID);
      seq_err   <= seq_err || viol;
    end
  end

  bcd_down_counter u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .tens     (tens),
    .ones     (ones),
    .zero     (cnt_zero)
  );

endmodule

// File: tb/tb_traffic_countdown.sv
// Directed bench for traffic_countdown: vector table plus multi-cycle sequences.
module tb_traffic_countdown;

  logic       clk = 1'b0;
  logic       reset;
  logic       red, yellow, green;
  logic [3:0] tens, ones, tens2, ones2;
  logic       walk, ped_flash, dont_walk, phase_err, seq_err;
  logic       walk2, ped_flash2, dont_walk2, phase_err2, seq_err2;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  traffic_countdown dut (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green),
    .tens(tens), .ones(ones), .walk(walk), .ped_flash(ped_flash),
    .dont_walk(dont_walk), .phase_err(phase_err), .seq_err(seq_err)
  );

  traffic_countdown #(.RED_TIME(9), .FLASH_TIME(9)) dut2 (
    .clk(clk), .reset(reset), .red(red), .yellow(yellow), .green(green),
    .tens(tens2), .ones(ones2), .walk(walk2), .ped_flash(ped_flash2),
    .dont_walk(dont_walk2), .phase_err(phase_err2), .seq_err(seq_err2)
  );

  typedef struct {
    logic       rst;
    logic [2:0] lamps;
    int         n;
    logic [3:0] t;
    logic [3:0] o;
    logic       w;
    logic       f;
    logic       d;
    logic       pe;
    logic       se;
    string      name;
  } vec_t;

  vec_t vecs[$];

  localparam logic [2:0] L_R = 3'b100;
  localparam logic [2:0] L_Y = 3'b010;
  localparam logic [2:0] L_G = 3'b001;

  function automatic logic [12:0] obs1();
    return {tens, ones, walk, ped_flash, dont_walk, phase_err, seq_err};
  endfunction

  function automatic logic [12:0] obs2();
    return {tens2, ones2, walk2, ped_flash2, dont_walk2, phase_err2, seq_err2};
  endfunction

  task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
    checks++;
    if (got !== exp) begin
      $display("FAIL %s: got t=%0d o=%0d w=%b f=%b dw=%b pe=%b se=%b, expected t=%0d o=%0d w=%b f=%b dw=%b pe=%b se=%b",
               name, got[12:9], got[8:5], got[4], got[3], got[2], got[1], got[0],
               exp[12:9], exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end else begin
      passed++;
    end
  endtask

  task automatic add(input logic rst, input logic [2:0] lamps, input int n,
                     input int disp, input logic w, input logic f, input logic d,
                     input logic pe, input logic se, input string name);
    vec_t v;
    v.rst = rst; v.lamps = lamps; v.n = n;
    v.t = 4'(disp / 10); v.o = 4'(disp % 10);
    v.w = w; v.f = f; v.d = d; v.pe = pe; v.se = se; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    {red, yellow, green} = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    {red, yellow, green} = 3'b000;

    //    rst lamps   n  disp w f d pe se
    add(0, 3'b000,  2,  0, 0, 0, 1, 0, 0, "reset_values");
    add(1, L_R,     1, 30, 1, 0, 0, 0, 0, "red_load_30");
    add(1, L_R,     1, 29, 1, 0, 0, 0, 0, "red_29");
    add(1, L_R,    18, 11, 1, 0, 0, 0, 0, "red_11_walk");
    add(1, L_R,     1, 10, 0, 1, 0, 0, 0, "red_10_flash");
    add(1, L_R,     9,  1, 0, 1, 0, 0, 0, "red_01_flash");
    add(1, L_R,     1,  0, 0, 0, 1, 0, 0, "red_hold_00");
    add(1, L_Y,     1,  5, 0, 0, 1, 0, 0, "yel_load_5");
    add(1, L_Y,     4,  1, 0, 0, 1, 0, 0, "yel_01");
    add(1, L_G,     1, 60, 0, 0, 1, 0, 0, "grn_load_60");
    add(1, L_G,    22, 38, 0, 0, 1, 0, 0, "grn_38");
    add(1, L_G,     1, 37, 0, 0, 1, 0, 0, "grn_37");
    add(1, 3'b101,  1,  0, 0, 0, 1, 1, 0, "invalid_1");
    add(1, 3'b101,  2,  0, 0, 0, 1, 1, 0, "invalid_3");
    add(1, L_G,     1, 60, 0, 0, 1, 0, 0, "grn_reload_after_invalid");
    add(1, L_G,     1, 59, 0, 0, 1, 0, 0, "grn_59");
    add(1, L_Y,     1,  5, 0, 0, 1, 0, 0, "yel2_load");
    add(1, L_Y,     4,  1, 0, 0, 1, 0, 0, "yel2_01");
    add(1, L_R,     1, 30, 1, 0, 0, 0, 0, "red_legal_after_yel");
    add(1, L_G,     1, 60, 0, 0, 1, 0, 1, "red_to_grn_illegal");
    add(1, L_G,     1, 59, 0, 0, 1, 0, 1, "seq_err_sticky");
    add(1, 3'b000,  1,  0, 0, 0, 1, 1, 1, "dark_invalid");
    add(0, L_G,     1,  0, 0, 0, 1, 0, 0, "reset_mid_green");
    add(1, L_R,     1, 30, 1, 0, 0, 0, 0, "red_after_reset");
    add(1, L_Y,     5,  1, 0, 0, 1, 0, 0, "yel3_01");
    add(1, L_R,     1, 30, 1, 0, 0, 0, 1, "red_yel_red_illegal");
    add(1, L_R,     1, 29, 1, 0, 0, 0, 1, "red_yel_red_sticky");
    add(1, 3'b111,  1,  0, 0, 0, 1, 1, 1, "all_on_invalid");

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst;
      {red, yellow, green} = vecs[i].lamps;
      repeat (vecs[i].n) @(posedge clk);
      #1;
      check(vecs[i].name, obs1(),
            {vecs[i].t, vecs[i].o, vecs[i].w, vecs[i].f, vecs[i].d, vecs[i].pe, vecs[i].se});
    end

    // Free-running controller model: red 30, yel 5, grn 60, yel 5 ... for 200 cycles.
    begin
      logic [2:0] pat [4];
      int         dur [4];
      int         cyc;
      int         idx;
      pat = '{L_R, L_Y, L_G, L_Y};
      dur = '{30, 5, 60, 5};
      do_reset();
      cyc = 0;
      idx = 0;
      while (cyc < 200) begin
        {red, yellow, green} = pat[idx % 4];
        for (int k = 0; k < dur[idx % 4] && cyc < 200; k++) begin
          int   rem;
          logic is_red;
          @(posedge clk);
          #1;
          rem    = dur[idx % 4] - k;
          is_red = (pat[idx % 4] == L_R);
          check($sformatf("ctrl_cycle_%0d", cyc), obs1(),
                {4'(rem / 10), 4'(rem % 10), is_red && (rem > 10),
                 is_red && (rem <= 10), !is_red, 1'b0, 1'b0});
          cyc++;
        end
        idx++;
      end
    end

    // Short red with FLASH_TIME == RED_TIME: flashing for the whole phase, never walk.
    do_reset();
    {red, yellow, green} = L_R;
    for (int k = 0; k < 10; k++) begin
      int rem;
      @(posedge clk);
      #1;
      rem = (k < 9) ? 9 - k : 0;
      check($sformatf("sweep_red9_edge_%0d", k + 1), obs2(),
            {4'd0, 4'(rem), 1'b0, rem != 0, rem == 0, 1'b0, 1'b0});
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/traffic_countdown.md
Name: traffic_countdown

Overview:
- Downstream consumer of the traffic light controller's one-hot red/yellow/green outputs.
- Tracks each light phase and shows the remaining time as two BCD digits for the roadside countdown display.
- Drives the pedestrian walk / don't-walk / flashing-walk lamps.
- Flags malformed light patterns and illegal phase sequences.

Parameters:
- RED_TIME, 30, red phase length in clk cycles (1..99)
- YEL_TIME, 5, length of each yellow phase in cycles (1..99)
- GRN_TIME, 60, green phase length in cycles (1..99)
- FLASH_TIME, 10, final red cycles during which the walk lamp flashes (0..RED_TIME)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-low reset
- red  input  1  controller red lamp
- yellow  input  1  controller yellow lamp
- green  input  1  controller green lamp
- tens  output  4  BCD tens digit of remaining cycles
- ones  output  4  BCD ones digit of remaining cycles
- walk  output  1  pedestrian walk lamp, steady
- ped_flash  output  1  pedestrian walk lamp, flashing request
- dont_walk  output  1  pedestrian don't-walk lamp
- phase_err  output  1  last sampled light pattern not one-hot
- seq_err  output  1  sticky: illegal phase order seen

Behaviour:
- Reset (reset==0 at a rising edge) clears the following:
  - tens=0, ones=0, walk=0, ped_flash=0, dont_walk=1, phase_err=0, seq_err=0.
  - prev_phase=NONE.
  - Reset dominates all other events, including mid-phase.
- Phase decoding: {red,yellow,green} one-hot gives RED/YEL/GRN; any other pattern gives INVALID.
- Registered state:
  - prev_phase: last sampled phase.
  - last_colour: last valid non-yellow phase; resets to GRN so the first RED is legal.
- Each edge:
  - Phase change (cur != prev_phase, cur valid): load the BCD counter with the duration of cur (RED_TIME / YEL_TIME / GRN_TIME).
  - Same phase: if the counter is nonzero, decrement by one in BCD (ones==0 gives ones=9 and tens-1); otherwise hold at 00.
  - INVALID: load 00 and set phase_err=1 for that cycle. The next valid sample counts as a phase change and reloads.
- Timing:
  - Outputs lag the lamps by one cycle.
  - A 30-cycle red shows 30,29,...,1; the display never reaches 00 in normal operation.
- Legal order is RED→YEL→GRN→YEL→RED.
  - YEL must be entered from the opposite colour of the phase that follows it.
  - Check: a YEL→RED or YEL→GRN transition must target the colour opposite last_colour. Direct RED↔GRN transitions are also illegal.
  - A violation sets seq_err=1 until reset. The counter still loads the new phase duration, so the display stays usable.
- Transitions out of or into INVALID and the first phase after reset are never sequence errors.
- Pedestrian outputs (registered, same cycle as the counter):
  - walk=1 in RED while remaining > FLASH_TIME.
  - ped_flash=1 in RED while 1 ≤ remaining ≤ FLASH_TIME.
  - dont_walk=1 otherwise.
  - Exactly one of the three is high at all times.
- Parameter checks (elaboration): any value >99 is a fatal error; FLASH_TIME > RED_TIME is a fatal error.

Decomposition:
- traffic_pkg holds:
  - Phase enum NONE/RED/YEL/GRN/INVALID and the default durations.
  - The to_bcd(int) function used for the load values.
- Sub-module bcd_down_counter (2-digit, ports: clk, reset, load, load_val[7:0], dec, tens, ones, zero) is natural and reusable by the display team.

Test Plan:
- Reset low 2 cycles, then hold red=1 → first edge tens/ones=3/0, walk=1; after 20 more edges display 10 and ped_flash=1; after 29 edges display 01.
- Connect the real traffic controller and run 200 cycles → display sequence 30..1, 5..1, 60..1, 5..1, 30...; seq_err=0; dont_walk=1 throughout yellow and green.
- Drive red, then yellow, then red (yellow lasts 5 cycles) → seq_err=1 on the second red edge and stays 1; display reloads 30.
- Drive {1,0,1} for 3 cycles mid-green → phase_err=1, display 00, dont_walk=1; returning to green gives phase_err=0 and reload to 60.
- Pull reset low at green remaining 37 → next edge all outputs at reset values; after release a red input loads 30 with seq_err=0.
- Parameter sweep with RED_TIME=9, FLASH_TIME=9 → ped_flash high for the whole red phase, walk never asserts.
